// File: rtl/crc_engine.sv
// Parametrised serial CRC engine with framing, saturating bit counter and registered verdict.
// Define CRC_SERIALOUT_EN to build the serial emitter that shifts ~crc out MSB-first.
module crc_engine #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h1021,
    parameter logic [WIDTH-1:0] PRESET  = 16'hFFFF,
    parameter logic [WIDTH-1:0] RESIDUE = 16'h1D0F,
    parameter int              CNTW    = 12
) (
    input  logic             crcinclk,
    input  logic             reset,
    input  logic             start,
    input  logic             bitvalid,
    input  logic             crcbitin,
    input  logic             done,
    input  logic             shiftout,
    output logic [WIDTH-1:0] crc,
    output logic [CNTW-1:0]  bitcount,
    output logic             checkvalid,
    output logic             crcok,
    output logic             crcbitout,
    output logic             outvalid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1
`ifdef CRC_SERIALOUT_EN
        ,
        SHIFT = 2'd2
`endif
    } state_t;

    localparam logic [CNTW-1:0] MIN_BITS = CNTW'(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] crc_reg;
    logic [CNTW-1:0]  bitcount_reg;
    logic             checkvalid_reg;
    logic             crcok_reg;

    logic             fb;
    logic [WIDTH-1:0] crc_step;
    logic [WIDTH-1:0] crc_next;
    logic [CNTW-1:0]  bitcount_next;

    // One LFSR step; crc_next/bitcount_next already include the same-cycle bit.
    assign fb            = crcbitin ^ crc_reg[WIDTH-1];
    assign crc_step      = {crc_reg[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    assign crc_next      = bitvalid ? crc_step : crc_reg;
    assign bitcount_next = (bitvalid && (bitcount_reg != '1)) ? bitcount_reg + 1'b1 : bitcount_reg;

`ifdef CRC_SERIALOUT_EN
    localparam int              SHCNT_W    = $clog2(WIDTH);
    localparam logic [SHCNT_W-1:0] SHCNT_LAST = SHCNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   shreg_reg;
    logic [SHCNT_W-1:0] shcnt_reg;
    logic               outvalid_reg;
`endif

    always_ff @(posedge crcinclk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            crc_reg        <= PRESET;
            bitcount_reg   <= '0;
            checkvalid_reg <= 1'b0;
            crcok_reg      <= 1'b0;
`ifdef CRC_SERIALOUT_EN
            shreg_reg      <= '0;
            shcnt_reg      <= '0;
            outvalid_reg   <= 1'b0;
`endif
        end else begin
            checkvalid_reg <= 1'b0;
            if (start) begin
                state_reg    <= ACCUM;
                crc_reg      <= PRESET;
                bitcount_reg <= '0;
                crcok_reg    <= 1'b0;
`ifdef CRC_SERIALOUT_EN
                shreg_reg    <= '0;
                shcnt_reg    <= '0;
                outvalid_reg <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    ACCUM: begin
                        crc_reg      <= crc_next;
                        bitcount_reg <= bitcount_next;
                        // done outranks shiftout; runt frames never pass
                        if (done) begin
                            crcok_reg      <= (crc_next == RESIDUE) && (bitcount_next >= MIN_BITS);
                            checkvalid_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end
`ifdef CRC_SERIALOUT_EN
                        else if (shiftout) begin
                            shreg_reg    <= ~crc_next;
                            shcnt_reg    <= '0;
                            outvalid_reg <= 1'b1;
                            state_reg    <= SHIFT;
                        end
`endif
                    end
`ifdef CRC_SERIALOUT_EN
                    SHIFT: begin
                        shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
                        shcnt_reg <= shcnt_reg + 1'b1;
                        if (shcnt_reg == SHCNT_LAST) begin
                            outvalid_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end
`endif
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign crc        = crc_reg;
    assign bitcount   = bitcount_reg;
    assign checkvalid = checkvalid_reg;
    assign crcok      = crcok_reg;
    assign busy       = (state_reg != IDLE);

`ifdef CRC_SERIALOUT_EN
    assign outvalid  = outvalid_reg;
    assign crcbitout = outvalid_reg & shreg_reg[WIDTH-1];
`else
    logic unused_shiftout;
    assign unused_shiftout = shiftout;
    assign outvalid  = 1'b0;
    assign crcbitout = 1'b0;
`endif

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised serial CRC engine for the tag datapath. It generalises the fixed CRC-16 check register to any width, polynomial, preset and residue. It adds framing, a bit counter, a registered pass/fail verdict, and an optional serial emitter for appending the complemented CRC to backscatter replies. It sits between the bit-level demodulator/command parser and the reply builder, and serves both the CRC-16 check on select/access commands and CRC-16 generation on replies.

## Interface
Parameters:
- WIDTH, 16, CRC register width (≥ 4)
- POLY, 16'h1021, generator polynomial without the implicit x^WIDTH term
- PRESET, 16'hFFFF, register value after reset / start
- RESIDUE, 16'h1D0F, register value that marks a good frame (data followed by the complemented CRC)
- CNTW, 12, bit counter width

Ports:
- crcinclk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  in  1  synchronous frame start; re-presets the engine from any state
- bitvalid  in  1  crcbitin is valid this cycle
- crcbitin  in  1  serial data, MSB-first
- done  in  1  end of frame; request the check verdict
- shiftout  in  1  request serial emission of ~crc
- crc  out  WIDTH  registered CRC value
- bitcount  out  CNTW  bits absorbed since start; saturates at all-ones
- checkvalid  out  1  one-cycle verdict strobe
- crcok  out  1  verdict; holds until next start or reset
- crcbitout  out  1  serial CRC output, MSB-first
- outvalid  out  1  crcbitout is valid
- busy  out  1  high in ACCUM or SHIFT

## Operation
- Update per absorbed bit: fb = crcbitin ^ crc[WIDTH-1]; crc_next = {crc[WIDTH-2:0],0} ^ (fb ? POLY : 0).
  - WIDTH=16, POLY=1021 matches the legacy taps at bits 0, 5 and 12.
- States are IDLE, ACCUM and SHIFT. Reset enters IDLE.
- Any state, start=1 (highest priority):
  - crc←PRESET, bitcount←0, crcok←0, outvalid←0.
  - Go to ACCUM.
  - A bitvalid in the same cycle is ignored.
- IDLE: bitvalid, done and shiftout are ignored.
- ACCUM, bitvalid=1: crc←crc_next; bitcount increments, saturating.
- ACCUM, done=1:
  - The same-cycle bit, if any, is absorbed first.
  - crcok←(crc_next==RESIDUE) && (bitcount_next ≥ WIDTH); runt frames fail.
  - checkvalid←1 for one cycle. Go to IDLE.
- ACCUM, shiftout=1 (done=0):
  - The same-cycle bit is absorbed first.
  - Output shift register ←~crc_next. Go to SHIFT.
- done and shiftout in the same cycle: done wins; shiftout is dropped.
- SHIFT:
  - outvalid=1; crcbitout = shreg MSB; shreg shifts left each cycle.
  - After WIDTH cycles: outvalid←0, go to IDLE.
  - crc, bitvalid, done and shiftout are frozen or ignored.
- crc holds its value in IDLE, so the reply builder can read it after done.

## Timing
- Reset values: crc=PRESET, bitcount=0, checkvalid=0, crcok=0, crcbitout=0, outvalid=0, busy=0.
- crc and bitcount update the cycle after bitvalid is sampled.
- checkvalid and crcok are valid the cycle after done is sampled. checkvalid is high for exactly one cycle.
- First output bit appears the cycle after shiftout is sampled. outvalid is high for exactly WIDTH consecutive cycles.
- Reset mid-frame or mid-SHIFT clears all outputs immediately (asynchronously).
- start during SHIFT aborts emission: outvalid is 0 the next cycle.
- Throughput: one bit per cycle; back-to-back frames are possible with start in the cycle after done.

## Configuration
- CRC_SERIALOUT_EN defined:
  - SHIFT state and the output shift register are built.
  - shiftout behaves as in Operation.
- CRC_SERIALOUT_EN undefined:
  - SHIFT, shreg and its counter are removed.
  - shiftout is ignored; crcbitout and outvalid are tied to 0.
  - Generation is by reading ~crc in parallel.

## Test plan
- Reset assert mid-activity -> crc=16'hFFFF, bitcount=0, crcok/checkvalid/outvalid/busy=0 immediately.
- start, then ASCII "123456789" MSB-first (72 bits) -> crc=16'h29B1, bitcount=72, busy=1.
- After the above, shiftout (CRC_SERIALOUT_EN) -> outvalid for 16 cycles, serial 16'hD64E MSB-first, then busy=0.
- start, 72 bits + 16'hD64E, done on the last bit -> next-cycle checkvalid pulse, crcok=1, crc=16'h1D0F, bitcount=88. Repeat with one data bit flipped -> crcok=0.
- Runt frame: start, 8 bits, done -> checkvalid=1, crcok=0.
- start asserted during SHIFT with bitvalid=1 -> outvalid=0 next cycle, crc=16'hFFFF, bitcount=0 (bit ignored). done+shiftout together in ACCUM -> verdict produced, no emission.
